// File: rtl/grid_game.sv
// grid_game: room-grid adventure with lives, respawn and a move budget.
//
// The player starts in room (0,0) and moves one room per valid request.
// Picking up the sword allows the player to slay the dragon. Reaching the
// exit after the dragon is slain wins. Entering the dragon room without the
// sword costs a life and respawns the player at (0,0). Running out of lives
// or reaching MOVE_LIMIT valid moves ends the game (dead).
//
// Ports:
//   clock         system clock, rising edge
//   R             asynchronous reset, active low
//   n / s / e / w move request (y-1 / y+1 / x+1 / x-1); exactly one must be high
//   win           game won (terminal)
//   d             player dead (terminal)
//   sw            sword held
//   slain         dragon slain
//   pos_x, pos_y  current room
//   lives         remaining lives
//   moves         valid moves taken
//
// Build option: define GRID_GAME_WRAP_EN to make the grid edges wrap
// toroidally. When it is undefined, a move off the grid is a wall bump:
// position and move count stay unchanged.
module grid_game #(
    parameter int GRID_W     = 4,
    parameter int GRID_H     = 4,
    parameter int LIVES      = 3,
    parameter int MOVE_LIMIT = 63,
    parameter int SWORD_X    = 3,
    parameter int SWORD_Y    = 0,
    parameter int DRAGON_X   = 0,
    parameter int DRAGON_Y   = 3,
    parameter int EXIT_X     = 3,
    parameter int EXIT_Y     = 3,
    localparam int XW = (GRID_W > 2) ? $clog2(GRID_W) : 1,
    localparam int YW = (GRID_H > 2) ? $clog2(GRID_H) : 1,
    localparam int LW = $clog2(LIVES + 1),
    localparam int MW = $clog2(MOVE_LIMIT + 1)
) (
    input  logic          clock,
    input  logic          R,
    input  logic          n,
    input  logic          s,
    input  logic          e,
    input  logic          w,
    output logic          win,
    output logic          d,
    output logic          sw,
    output logic          slain,
    output logic [XW-1:0] pos_x,
    output logic [YW-1:0] pos_y,
    output logic [LW-1:0] lives,
    output logic [MW-1:0] moves
);

    typedef enum logic [1:0] {
        PLAY = 2'd0,
        WIN  = 2'd1,
        DEAD = 2'd2
    } state_t;

    state_t        state_reg, state_next;
    logic          win_reg, win_next;
    logic          d_reg, d_next;
    logic          sw_reg, sw_next;
    logic          slain_reg, slain_next;
    logic [XW-1:0] pos_x_reg, pos_x_next;
    logic [YW-1:0] pos_y_reg, pos_y_next;
    logic [LW-1:0] lives_reg, lives_next;
    logic [MW-1:0] moves_reg, moves_next;

    // Target room of the current request and whether it falls off the grid.
    logic [XW-1:0] tgt_x;
    logic [YW-1:0] tgt_y;
    logic          bump;
    logic          req_one;
    logic [MW-1:0] moves_inc;
    logic          at_sword, at_dragon, at_exit;
    logic          won, killed;

    assign req_one = ($countones({n, s, e, w}) == 1);

    always_comb begin
        tgt_x = pos_x_reg;
        tgt_y = pos_y_reg;
        bump  = 1'b0;
        if (n) begin
            if (pos_y_reg == '0) begin
`ifdef GRID_GAME_WRAP_EN
                tgt_y = YW'(GRID_H - 1);
`else
                bump  = 1'b1;
`endif
            end else begin
                tgt_y = pos_y_reg - YW'(1);
            end
        end else if (s) begin
            if (pos_y_reg == YW'(GRID_H - 1)) begin
`ifdef GRID_GAME_WRAP_EN
                tgt_y = '0;
`else
                bump  = 1'b1;
`endif
            end else begin
                tgt_y = pos_y_reg + YW'(1);
            end
        end else if (e) begin
            if (pos_x_reg == XW'(GRID_W - 1)) begin
`ifdef GRID_GAME_WRAP_EN
                tgt_x = '0;
`else
                bump  = 1'b1;
`endif
            end else begin
                tgt_x = pos_x_reg + XW'(1);
            end
        end else if (w) begin
            if (pos_x_reg == '0) begin
`ifdef GRID_GAME_WRAP_EN
                tgt_x = XW'(GRID_W - 1);
`else
                bump  = 1'b1;
`endif
            end else begin
                tgt_x = pos_x_reg - XW'(1);
            end
        end
    end

    assign at_sword  = (tgt_x == XW'(SWORD_X))  && (tgt_y == YW'(SWORD_Y));
    assign at_dragon = (tgt_x == XW'(DRAGON_X)) && (tgt_y == YW'(DRAGON_Y));
    assign at_exit   = (tgt_x == XW'(EXIT_X))   && (tgt_y == YW'(EXIT_Y));
    // Terminal states stop all play, so moves never passes MOVE_LIMIT.
    assign moves_inc = moves_reg + MW'(1);

    always_comb begin
        state_next = state_reg;
        win_next   = win_reg;
        d_next     = d_reg;
        sw_next    = sw_reg;
        slain_next = slain_reg;
        pos_x_next = pos_x_reg;
        pos_y_next = pos_y_reg;
        lives_next = lives_reg;
        moves_next = moves_reg;
        won        = 1'b0;
        killed     = 1'b0;

        if (state_reg == PLAY && req_one && !bump) begin
            moves_next = moves_inc;
            pos_x_next = tgt_x;
            pos_y_next = tgt_y;
            if (at_sword) begin
                sw_next = 1'b1;
            end
            // Sword and dragon rooms are distinct, so sw_reg already reflects
            // whether the player is armed when entering the dragon room.
            if (at_dragon && !slain_reg) begin
                if (sw_reg) begin
                    slain_next = 1'b1;
                end else begin
                    lives_next = lives_reg - LW'(1);
                    pos_x_next = '0;
                    pos_y_next = '0;
                    killed     = (lives_reg == LW'(1));
                end
            end else if (at_exit && slain_reg) begin
                won = 1'b1;
            end

            // Winning beats both kinds of death on the same edge.
            if (won) begin
                state_next = WIN;
                win_next   = 1'b1;
            end else if (killed || moves_inc == MW'(MOVE_LIMIT)) begin
                state_next = DEAD;
                d_next     = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge R) begin
        if (!R) begin
            state_reg <= PLAY;
            win_reg   <= 1'b0;
            d_reg     <= 1'b0;
            sw_reg    <= 1'b0;
            slain_reg <= 1'b0;
            pos_x_reg <= '0;
            pos_y_reg <= '0;
            lives_reg <= LW'(LIVES);
            moves_reg <= '0;
        end else begin
            state_reg <= state_next;
            win_reg   <= win_next;
            d_reg     <= d_next;
            sw_reg    <= sw_next;
            slain_reg <= slain_next;
            pos_x_reg <= pos_x_next;
            pos_y_reg <= pos_y_next;
            lives_reg <= lives_next;
            moves_reg <= moves_next;
        end
    end

    assign win   = win_reg;
    assign d     = d_reg;
    assign sw    = sw_reg;
    assign slain = slain_reg;
    assign pos_x = pos_x_reg;
    assign pos_y = pos_y_reg;
    assign lives = lives_reg;
    assign moves = moves_reg;

endmodule

// File: tb/tb_grid_game.sv
// Testbench for grid_game. Three instances share clock, reset and move
// inputs:
//   a: default 4x4 configuration
//   b: 4x4 with MOVE_LIMIT=4
//   c: 2x2 with sword (1,0), dragon (1,1), exit (0,1), MOVE_LIMIT=3
// A rule-level game model per instance is checked against every DUT on each
// falling clock edge; hand-computed literals pin key points of the story.
module tb_grid_game;

    logic clock = 1'b0;
    logic R = 1'b0;
    logic n = 1'b0, s = 1'b0, e = 1'b0, w = 1'b0;

    always #5 clock = ~clock;

    logic       a_win, a_d, a_sw, a_slain;
    logic [1:0] a_x, a_y, a_lives;
    logic [5:0] a_moves;
    logic       b_win, b_d, b_sw, b_slain;
    logic [1:0] b_x, b_y, b_lives;
    logic [2:0] b_moves;
    logic       c_win, c_d, c_sw, c_slain;
    logic [0:0] c_x, c_y;
    logic [1:0] c_lives;
    logic [1:0] c_moves;

    grid_game dut_a (
        .clock(clock), .R(R), .n(n), .s(s), .e(e), .w(w),
        .win(a_win), .d(a_d), .sw(a_sw), .slain(a_slain),
        .pos_x(a_x), .pos_y(a_y), .lives(a_lives), .moves(a_moves)
    );

    grid_game #(.MOVE_LIMIT(4)) dut_b (
        .clock(clock), .R(R), .n(n), .s(s), .e(e), .w(w),
        .win(b_win), .d(b_d), .sw(b_sw), .slain(b_slain),
        .pos_x(b_x), .pos_y(b_y), .lives(b_lives), .moves(b_moves)
    );

    grid_game #(
        .GRID_W(2), .GRID_H(2), .MOVE_LIMIT(3),
        .SWORD_X(1), .SWORD_Y(0), .DRAGON_X(1), .DRAGON_Y(1),
        .EXIT_X(0), .EXIT_Y(1)
    ) dut_c (
        .clock(clock), .R(R), .n(n), .s(s), .e(e), .w(w),
        .win(c_win), .d(c_d), .sw(c_sw), .slain(c_slain),
        .pos_x(c_x), .pos_y(c_y), .lives(c_lives), .moves(c_moves)
    );

    // Per-instance configuration for the model.
    int gw[3] = '{4, 4, 2};
    int gh[3] = '{4, 4, 2};
    int ml[3] = '{63, 4, 3};
    int sx[3] = '{3, 3, 1};
    int sy[3] = '{0, 0, 0};
    int dx[3] = '{0, 0, 1};
    int dy[3] = '{3, 3, 1};
    int ex[3] = '{3, 3, 0};
    int ey[3] = '{3, 3, 1};

    // Model state.
    int m_x[3], m_y[3], m_lives[3], m_moves[3];
    bit m_sw[3], m_slain[3], m_win[3], m_d[3];

    int vectors = 0;
    int errs = 0;

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_x[k] = 0; m_y[k] = 0; m_lives[k] = 3; m_moves[k] = 0;
            m_sw[k] = 0; m_slain[k] = 0; m_win[k] = 0; m_d[k] = 0;
        end
    endtask

    // One clock edge of the game rules for instance k.
    task automatic model_step(int k, bit bn, bit bs, bit be, bit bw);
        int tx, ty;
        if (m_win[k] || m_d[k]) return;
        if (int'(bn) + int'(bs) + int'(be) + int'(bw) != 1) return;
        tx = m_x[k] + int'(be) - int'(bw);
        ty = m_y[k] + int'(bs) - int'(bn);
`ifdef GRID_GAME_WRAP_EN
        tx = (tx + gw[k]) % gw[k];
        ty = (ty + gh[k]) % gh[k];
`else
        if (tx < 0 || tx >= gw[k] || ty < 0 || ty >= gh[k]) return;
`endif
        m_moves[k]++;
        m_x[k] = tx;
        m_y[k] = ty;
        if (tx == sx[k] && ty == sy[k]) m_sw[k] = 1;
        if (tx == dx[k] && ty == dy[k] && !m_slain[k]) begin
            if (m_sw[k]) begin
                m_slain[k] = 1;
            end else begin
                m_lives[k]--;
                m_x[k] = 0;
                m_y[k] = 0;
                if (m_lives[k] == 0) m_d[k] = 1;
            end
        end else if (tx == ex[k] && ty == ey[k] && m_slain[k]) begin
            m_win[k] = 1;
        end
        if (!m_win[k] && m_moves[k] == ml[k]) m_d[k] = 1;
    endtask

    always @(posedge clock or negedge R) begin
        if (!R) begin
            model_reset();
        end else begin
            for (int k = 0; k < 3; k++) model_step(k, n, s, e, w);
        end
    end

    // Cycle-by-cycle comparison of all instances against the model.
    always @(negedge clock) begin
        int g[8];
        int x[8];
        for (int k = 0; k < 3; k++) begin
            case (k)
                0: g = '{int'(a_win), int'(a_d), int'(a_sw), int'(a_slain),
                         int'(a_x), int'(a_y), int'(a_lives), int'(a_moves)};
                1: g = '{int'(b_win), int'(b_d), int'(b_sw), int'(b_slain),
                         int'(b_x), int'(b_y), int'(b_lives), int'(b_moves)};
                default: g = '{int'(c_win), int'(c_d), int'(c_sw), int'(c_slain),
                               int'(c_x), int'(c_y), int'(c_lives), int'(c_moves)};
            endcase
            x = '{int'(m_win[k]), int'(m_d[k]), int'(m_sw[k]), int'(m_slain[k]),
                  m_x[k], m_y[k], m_lives[k], m_moves[k]};
            vectors++;
            if (g != x) begin
                errs++;
                $display("FAIL model_inst%0d t=%0t got win/d/sw/slain/x/y/lives/moves=%0d/%0d/%0d/%0d/%0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d/%0d/%0d/%0d/%0d",
                         k, $time, g[0], g[1], g[2], g[3], g[4], g[5], g[6], g[7],
                         x[0], x[1], x[2], x[3], x[4], x[5], x[6], x[7]);
            end
        end
    end

    task automatic chk(string name, int got, int exp);
        vectors++;
        if (got != exp) begin
            errs++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    // Apply one request across one rising edge, then clear the inputs.
    task automatic press(input logic [3:0] nsew);
        {n, s, e, w} = nsew;
        @(posedge clock);
        #1;
        {n, s, e, w} = 4'b0000;
    endtask

    task automatic do_reset();
        R = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        R = 1'b1;
    endtask

    localparam logic [3:0] KN = 4'b1000, KS = 4'b0100, KE = 4'b0010, KW = 4'b0001;

    initial begin
        do_reset();
        chk("reset_pos_x", int'(a_x), 0);
        chk("reset_pos_y", int'(a_y), 0);
        chk("reset_lives", int'(a_lives), 3);
        chk("reset_moves", int'(a_moves), 0);
        chk("reset_flags", int'({a_sw, a_slain, a_win, a_d}), 0);

        // Bumps and multi-press.
`ifndef GRID_GAME_WRAP_EN
        press(KN);
        chk("bump_n_moves", int'(a_moves), 0);
        chk("bump_n_pos_y", int'(a_y), 0);
`endif
        press(KN | KE);
        chk("multi_press_moves", int'(a_moves), 0);
        press(KE);
        chk("east_pos_x", int'(a_x), 1);
        chk("east_moves", int'(a_moves), 1);

        // Three unarmed dragon visits.
        do_reset();
        repeat (3) press(KS);
        chk("dragon1_lives", int'(a_lives), 2);
        chk("dragon1_pos", int'({a_x, a_y}), 0);
        chk("dragon1_moves", int'(a_moves), 3);
        repeat (6) press(KS);
        chk("dragon3_lives", int'(a_lives), 0);
        chk("dragon3_d", int'(a_d), 1);
        press(KE);
        chk("dead_hold_pos_x", int'(a_x), 0);
        chk("dead_hold_moves", int'(a_moves), 9);

        // Full winning path.
        do_reset();
        repeat (3) press(KE);
        chk("sword_sw", int'(a_sw), 1);
        repeat (3) press(KS);
        chk("exit_unslain_win", int'(a_win), 0);
        repeat (3) press(KW);
        chk("slay_slain", int'(a_slain), 1);
        chk("slay_pos_y", int'(a_y), 3);
        repeat (3) press(KE);
        chk("win_win", int'(a_win), 1);
        chk("win_moves", int'(a_moves), 12);
        press(KN);
        chk("win_hold_pos_y", int'(a_y), 3);

        // Move-limit death on instance b.
        do_reset();
        press(KE); press(KW); press(KE);
        chk("limit_before_d", int'(b_d), 0);
        press(KW);
        chk("limit_d", int'(b_d), 1);
        chk("limit_moves", int'(b_moves), 4);

        // Win on the final allowed move on instance c beats move-limit death.
        do_reset();
        press(KE); press(KS); press(KW);
        chk("limit_win", int'(c_win), 1);
        chk("limit_win_not_d", int'(c_d), 0);
        chk("limit_win_moves", int'(c_moves), 3);

        // Asynchronous reset pulse mid-game.
        do_reset();
        press(KE); press(KE);
        #2;
        R = 1'b0;
        #1;
        chk("async_rst_pos_x", int'(a_x), 0);
        chk("async_rst_moves", int'(a_moves), 0);
        chk("async_rst_lives", int'(a_lives), 3);
        @(posedge clock);
        #1;
        R = 1'b1;

`ifdef GRID_GAME_WRAP_EN
        do_reset();
        press(KW);
        chk("wrap_w_pos_x", int'(a_x), 3);
        chk("wrap_w_sw", int'(a_sw), 1);
        chk("wrap_w_moves", int'(a_moves), 1);
        press(KN);
        chk("wrap_n_pos_y", int'(a_y), 3);
        chk("wrap_n_win", int'(a_win), 0);
        chk("wrap_n_moves", int'(a_moves), 2);
`endif

        // A directed wander exercising walls and corners against the model.
        do_reset();
        begin
            logic [3:0] walk[12] = '{KN, KW, KE, KE, KE, KE, KS, KS, KS, KS, KW, KN};
            for (int i = 0; i < 12; i++) press(walk[i]);
        end

        repeat (2) @(posedge clock);
        @(negedge clock);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
